ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Multi-key PS/2 scan-code tracker between the PS/2 byte receiver and the seven-segment display logic.
//  Decodes make, break, E0-extended and typematic-repeat sequences and holds up to NUM_SLOTS concurrently pressed keys.
//  Produces the last new key for display, a display enable while any key is held, press/release pulses and a wrapping press counter.
// PARAMETERS
//  NUM_SLOTS  4  number of simultaneously held keys tracked (>=1)
//  CNT_W      8  width of press_cnt (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  rst        in   1   asynchronous, active-high reset
//  ps2_data   in   8   received scan-code byte
//  ps2_valid  in   1   one-cycle strobe: ps2_data holds a new byte
//  clr        in   1   synchronous clear: table, counters and flags
//  seg_en     out  1   1 while held_cnt != 0 (display enable)
//  last_key   out  9   {ext, code} of the most recent NEW make
//  key_down   out  1   1-cycle pulse: new key entered the table
//  key_up     out  1   1-cycle pulse: held key released
//  key_rpt    out  1   1-cycle pulse: make of an already-held key
//  press_cnt  out  CNT_W  count of new makes accepted into the table
//  held_cnt   out  $clog2(NUM_SLOTS+1)  number of occupied slots
//  ovf        out  1   sticky: a new make found no free slot
//  proto_err  out  1   1-cycle pulse: illegal byte after a prefix
// BEHAVIOUR
//  Reset: FSM=WAIT; all slots invalid; every output 0 (last_key=9'h000).
//  FSM states: WAIT, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
//   WAIT: E0->EXT; F0->BRK; code->make(ext=0), stay WAIT.
//   EXT:  F0->EXT_BRK; code->make(ext=1), ->WAIT.
//   BRK:  E0->EXT_BRK (tolerated); code->break(ext=0), ->WAIT.
//   EXT_BRK: code->break(ext=1), ->WAIT.
//   FSM only advances on cycles with ps2_valid=1.
//  Control bytes 00,AA,EE,FA,FC,FD,FE,FF: ignored in WAIT (no state change);
//   in EXT/BRK/EXT_BRK -> proto_err pulse, ->WAIT, byte dropped, table unchanged.
//   Repeated prefix (E0 in EXT, F0 in BRK/EXT_BRK): proto_err, ->WAIT, byte dropped.
//  Make {ext,code}: matches a valid slot -> key_rpt only.
//   Else lowest-index free slot takes it; key_down, press_cnt+1, held_cnt+1, last_key={ext,code}.
//   Else (table full) -> ovf set (sticky until rst/clr); no other change.
//  Break {ext,code}: matching slot invalidated; key_up, held_cnt-1.
//   No match -> ignored silently (no pulse, no error).
//  Latency: pulses, counters, last_key, seg_en update on the clock edge that samples
//   the final byte (valid visible 1 cycle after the ps2_valid cycle); pulses last exactly 1 cycle.
//  ext=0 and ext=1 with same code are distinct keys.
//  last_key is retained after release (seg_en=0 blanks the display).
//  press_cnt wraps 2^CNT_W-1 -> 0 without flag. held_cnt never exceeds NUM_SLOTS.
//  clr=1: slots invalid, press_cnt=0, held_cnt=0, ovf=0, last_key=0, FSM=WAIT, pulses 0;
//   clr wins over ps2_valid in the same cycle (byte dropped).
//  Reset asserted mid-sequence (e.g. after E0): async return to reset values; the
//   next byte is decoded from WAIT.
//  Pulses are mutually exclusive: at most one of key_down/key_up/key_rpt/proto_err per cycle.
// TESTING
//  1 Bytes 1C, F0, 1C -> key_down@1C, last_key=01C, seg_en 1 then 0, key_up, press_cnt=1.
//  2 E0 75, E0 F0 75 -> last_key=175, key_down then key_up; 1C held alongside -> held_cnt=2.
//  3 1C,1C,1C (typematic) -> one key_down, two key_rpt, press_cnt=1, held_cnt=1.
//  4 NUM_SLOTS=4: makes 15,1D,24,2D,2C -> held_cnt=4, ovf=1, last_key=02D; F0 2C -> no key_up.
//  5 F0 AA -> proto_err pulse, FSM WAIT; next 1C decoded as make; E0 E0 -> proto_err.
//  6 CNT_W=8: 256 make/break pairs -> press_cnt=0; rst after E0 then 1C -> ext=0 make; clr+valid -> byte dropped.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Sits between the PS/2 byte receiver and the seven-segment display logic.
//   It decodes make, break, E0-extended and typematic-repeat byte sequences,
//   and it keeps a table of up to NUM_SLOTS keys that are held at the same time.
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   ps2_data   received scan-code byte, qualified by ps2_valid
//   ps2_valid  one-cycle strobe for ps2_data
//   clr        synchronous clear of table, counters and flags (wins over ps2_valid)
//   seg_en     display enable while any key is held
//   last_key   {ext, code} of the most recent new make (kept after release)
//   key_down   1-cycle pulse: a new key entered the table
//   key_up     1-cycle pulse: a held key was released
//   key_rpt    1-cycle pulse: a make arrived for a key that is already held
//   press_cnt  wrapping count of new makes accepted into the table
//   held_cnt   number of occupied slots
//   ovf        sticky: a new make found no free slot
//   proto_err  1-cycle pulse: illegal byte after a prefix

// One table entry: it holds one {ext, code} key and matches it against the
// decoded key of the current byte.
module ps2_key_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       set,
  input  logic       rel,
  input  logic [8:0] key_in,
  output logic       busy,
  output logic       match
);
  logic [8:0] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      key_q <= '0;
    end else if (clr) begin
      busy  <= 1'b0;
    end else if (set) begin
      busy  <= 1'b1;
      key_q <= key_in;
    end else if (rel) begin
      busy  <= 1'b0;
    end
  end

  assign match = busy && (key_q == key_in);
endmodule

module ps2_key_tracker #(
  parameter  int NUM_SLOTS = 4,
  parameter  int CNT_W     = 8,
  localparam int HW        = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             clr,
  output logic             seg_en,
  output logic [8:0]       last_key,
  output logic             key_down,
  output logic             key_up,
  output logic             key_rpt,
  output logic [CNT_W-1:0] press_cnt,
  output logic [HW-1:0]    held_cnt,
  output logic             ovf,
  output logic             proto_err
);
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  typedef enum logic [1:0] {WAIT, EXT, BRK, EXT_BRK} state_t;

  localparam logic [HW-1:0]    H_ONE = HW'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t state, state_nx;

  logic is_e0, is_f0, is_ctrl;
  logic mk, bk, perr;
  key_t key;

  logic [NUM_SLOTS-1:0] busy_vec, match_vec, set_vec, rel_vec;
  logic hit, full, found;
  logic new_mk, rpt, mk_full, brk_hit;

  // These control and response bytes never carry a key code.
  always_comb begin
    is_ctrl = 1'b0;
    case (ps2_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

  assign is_e0 = (ps2_data == 8'hE0);
  assign is_f0 = (ps2_data == 8'hF0);

  // Sequence decoder
  always_comb begin
    state_nx = state;
    mk       = 1'b0;
    bk       = 1'b0;
    perr     = 1'b0;
    key      = '{ext: 1'b0, code: ps2_data};
    if (ps2_valid) begin
      case (state)
        WAIT: begin
          if (is_e0)         state_nx = EXT;
          else if (is_f0)    state_nx = BRK;
          else if (!is_ctrl) mk = 1'b1;
        end
        EXT: begin
          state_nx = WAIT;
          if (is_f0)                 state_nx = EXT_BRK;
          else if (is_e0 || is_ctrl) perr = 1'b1;
          else begin
            mk      = 1'b1;
            key.ext = 1'b1;
          end
        end
        BRK: begin
          state_nx = WAIT;
          // A prefix sent out of order (F0 E0) is tolerated as E0 F0.
          if (is_e0)                 state_nx = EXT_BRK;
          else if (is_f0 || is_ctrl) perr = 1'b1;
          else                       bk = 1'b1;
        end
        default: begin
          state_nx = WAIT;
          if (is_e0 || is_f0 || is_ctrl) perr = 1'b1;
          else begin
            bk      = 1'b1;
            key.ext = 1'b1;
          end
        end
      endcase
    end
    if (clr) begin
      state_nx = WAIT;
      mk       = 1'b0;
      bk       = 1'b0;
      perr     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= state_nx;
  end

  // Slot table
  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      ps2_key_slot u_slot (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .set    (set_vec[g]),
        .rel    (rel_vec[g]),
        .key_in (key),
        .busy   (busy_vec[g]),
        .match  (match_vec[g])
      );
    end
  endgenerate

  assign hit     = |match_vec;
  assign full    = &busy_vec;
  assign new_mk  = mk && !hit && !full;
  assign rpt     = mk && hit;
  assign mk_full = mk && !hit && full;
  assign brk_hit = bk && hit;

  // A new make goes to the lowest-index free slot. A break releases the one
  // matching slot. The same key is never stored twice.
  always_comb begin
    set_vec = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (new_mk && !busy_vec[i] && !found) begin
        set_vec[i] = 1'b1;
        found      = 1'b1;
      end
    end
    rel_vec = bk ? match_vec : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_down  <= 1'b0;
      key_up    <= 1'b0;
      key_rpt   <= 1'b0;
      proto_err <= 1'b0;
      press_cnt <= '0;
      held_cnt  <= '0;
      ovf       <= 1'b0;
      last_key  <= '0;
    end else begin
      key_down  <= new_mk;
      key_up    <= brk_hit;
      key_rpt   <= rpt;
      proto_err <= perr;
      if (clr) begin
        press_cnt <= '0;
        held_cnt  <= '0;
        ovf       <= 1'b0;
        last_key  <= '0;
      end else begin
        if (new_mk) begin
          press_cnt <= press_cnt + C_ONE;
          held_cnt  <= held_cnt + H_ONE;
          last_key  <= key;
        end
        if (brk_hit) held_cnt <= held_cnt - H_ONE;
        if (mk_full) ovf <= 1'b1;
      end
    end
  end

  assign seg_en = (held_cnt != '0);
endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;
  localparam int NUM_SLOTS = 4;
  localparam int CNT_W     = 8;
  localparam int HW        = $clog2(NUM_SLOTS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ps2_data = 8'h00;
  logic             ps2_valid = 1'b0;
  logic             clr = 1'b0;
  logic             seg_en;
  logic [8:0]       last_key;
  logic             key_down, key_up, key_rpt, ovf, proto_err;
  logic [CNT_W-1:0] press_cnt;
  logic [HW-1:0]    held_cnt;

  ps2_key_tracker #(.NUM_SLOTS(NUM_SLOTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid), .clr(clr),
    .seg_en(seg_en), .last_key(last_key), .key_down(key_down), .key_up(key_up),
    .key_rpt(key_rpt), .press_cnt(press_cnt), .held_cnt(held_cnt), .ovf(ovf),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             down, up, rpt, perr, seg, ovf;
    logic [8:0]       lk;
    logic [CNT_W-1:0] pc;
    logic [HW-1:0]    hc;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   nbyte = 0;

  // Reference model. It keeps the pending prefixes as two flags and the
  // held keys as a set.
  bit               m_ext, m_brk;
  logic [8:0]       m_held[$];
  logic [CNT_W-1:0] m_pc;
  logic             m_ovf;
  logic [8:0]       m_lk;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = {}; m_pc = '0; m_ovf = 0; m_lk = '0;
  endtask

  function automatic obs_t model_obs(bit d, bit u, bit r, bit p);
    obs_t o;
    o.down = d; o.up = u; o.rpt = r; o.perr = p;
    o.seg = (m_held.size() != 0); o.ovf = m_ovf; o.lk = m_lk; o.pc = m_pc;
    o.hc = HW'(m_held.size());
    return o;
  endfunction

  task automatic model_step(input logic [7:0] b);
    bit ctrl, d, u, r, p, kext, pending;
    int idx;
    logic [8:0] k;
    ctrl = (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF});
    d = 0; u = 0; r = 0; p = 0;
    pending = m_ext || m_brk;
    if (b == 8'hE0 && !m_ext) m_ext = 1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1;
    else if (ctrl || b == 8'hE0 || b == 8'hF0) begin
      if (pending) p = 1;
      m_ext = 0; m_brk = 0;
    end else begin
      kext = m_ext;
      k = {kext, b};
      idx = -1;
      foreach (m_held[i]) if (m_held[i] == k) idx = i;
      if (m_brk) begin
        if (idx >= 0) begin m_held.delete(idx); u = 1; end
      end else if (idx >= 0) r = 1;
      else if (m_held.size() < NUM_SLOTS) begin
        m_held.push_back(k); d = 1; m_pc = m_pc + 1'b1; m_lk = k;
      end else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
    exp_q.push_back(model_obs(d, u, r, p));
  endtask

  // Driver
  task automatic send(input logic [7:0] b);
    model_step(b);
    ps2_data = b; ps2_valid = 1'b1;
    @(posedge clk); #1;
    ps2_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_clr(input bit with_byte, input logic [7:0] b);
    model_reset();
    exp_q.push_back(model_obs(0, 0, 0, 0));
    clr = 1'b1; ps2_valid = with_byte; ps2_data = b;
    @(posedge clk); #1;
    clr = 1'b0; ps2_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    logic [31:0] act;
    act = {seg_en, last_key, key_down, key_up, key_rpt, press_cnt, held_cnt, ovf, proto_err};
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL %s: got %h want 0", name, act);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); #1;
    rst = 1'b1;
    #2;
    check_zero("rst_state_mid");
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor
  logic chk_due = 1'b0;
  always @(posedge clk) chk_due <= (ps2_valid || clr) && !rst;

  always @(negedge clk) begin
    obs_t act, e;
    act = '{down: key_down, up: key_up, rpt: key_rpt, perr: proto_err, seg: seg_en,
            ovf: ovf, lk: last_key, pc: press_cnt, hc: held_cnt};
    if (chk_due) begin
      nbyte++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL byte%0d: DUT output with empty expect queue, got %h", nbyte, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL byte%0d: got dn%b up%b rp%b pe%b seg%b ovf%b lk%h pc%h hc%h want dn%b up%b rp%b pe%b seg%b ovf%b lk%h pc%h hc%h",
                   nbyte, act.down, act.up, act.rpt, act.perr, act.seg, act.ovf, act.lk, act.pc, act.hc,
                   e.down, e.up, e.rpt, e.perr, e.seg, e.ovf, e.lk, e.pc, e.hc);
        end
      end
    end else if (!rst) begin
      total++;
      if ({key_down, key_up, key_rpt, proto_err} != 4'b0) begin
        bad++;
        $display("FAIL idle_pulse: got %b want 0000", {key_down, key_up, key_rpt, proto_err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool_code[8] = '{8'h15, 8'h1C, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h75, 8'h6B};
  logic [7:0] pool_ctrl[8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  initial begin
    model_reset();
    #12;
    check_zero("rst_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // Make and break of one key
    send(8'h1C); send(8'hF0); send(8'h1C);
    // Extended key held together with 1C, then the prefix order F0 E0
    send(8'h1C); send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h75); send(8'hF0); send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1C);
    // Typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    // Table full
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    send(8'hF0); send(8'h2C);
    send_clr(0, 8'h00);
    // Protocol errors
    send(8'hF0); send(8'hAA); send(8'h1C); send(8'hE0); send(8'hE0);
    send(8'hF0); send(8'hF0); send(8'hAA); send(8'hF0); send(8'h1C);
    // press_cnt wrap
    for (int i = 0; i < 256; i++) begin send(8'h1C); send(8'hF0); send(8'h1C); end
    // Reset in the middle of a sequence, then clr together with a byte
    send(8'hE0);
    pulse_rst();
    send(8'h1C);
    send_clr(1, 8'h2D);
    send(8'h24);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 1)       send_clr(1, pool_code[$urandom_range(0, 7)]);
      else if (sel < 70) send(pool_code[$urandom_range(0, 7)]);
      else if (sel < 82) send(8'hE0);
      else if (sel < 94) send(8'hF0);
      else               send(pool_ctrl[$urandom_range(0, 7)]);
    end

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
